// File: rtl/id_lmsm_expander_pkg.sv
// Shared ISA constants, IR field positions and decode-stage state encoding
// for the LM/SM expander.
package id_lmsm_expander_pkg;

  localparam int DATA_W = 16;
  localparam int MASK_W = 8;
  localparam int IDX_W  = 3;
  localparam int OFF_W  = 6;

  // IR field least-significant bit positions
  localparam int OPC_LSB = 12;
  localparam int RA_LSB  = 9;
  localparam int RB_LSB  = 6;
  localparam int RC_LSB  = 3;

  localparam logic [3:0] OP_LW = 4'b0100;
  localparam logic [3:0] OP_SW = 4'b0101;
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  localparam logic [MASK_W-1:0] MASK_MSB = {1'b1, {(MASK_W-1){1'b0}}};

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_SEQ  = 1'b1
  } lmsm_state_e;

  function automatic logic is_lmsm(input logic [3:0] op);
    return (op == OP_LM) || (op == OP_SM);
  endfunction

  // LM expands into LW micro-ops, SM into SW micro-ops
  function automatic logic [3:0] micro_op(input logic [3:0] op);
    return (op == OP_SM) ? OP_SW : OP_LW;
  endfunction

endpackage

// File: rtl/id_lmsm_expander_prio_enc.sv
// Highest-set-bit encoder for the LM/SM register mask. Mask bit 7 names R0 and
// bit 0 names R7, so the returned index is directly the register number.
module lmsm_prio_enc
  import id_lmsm_expander_pkg::*;
(
  input  logic [MASK_W-1:0] mask,
  output logic [IDX_W-1:0]  idx,
  output logic              any_set
);

  // Ascending scan: the last hit (highest bit) wins.
  always_comb begin
    idx     = '0;
    any_set = 1'b0;
    for (int i = 0; i < MASK_W; i++) begin
      if (mask[i]) begin
        idx     = IDX_W'(MASK_W - 1 - i);
        any_set = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_lmsm_expander.sv
// Decode-stage register: latches IF/ID output, slices IR fields, and expands
// LM/SM into one LW/SW micro-op per set mask bit while holding fetch.
module id_lmsm_expander
  import id_lmsm_expander_pkg::*;
#(
  parameter int OFFSET_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ir_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] pc_out,
  output logic              valid_out,
  output logic [3:0]        opcode_out,
  output logic [2:0]        ra_out,
  output logic [2:0]        rb_out,
  output logic [2:0]        rc_out,
  output logic [5:0]        imm6_out,
  output logic [8:0]        imm9_out,
  output logic              hold_fetch,
  output logic              lmsm_busy
);

  lmsm_state_e       state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [OFF_W-1:0]  off_q, off_d;

  logic [MASK_W-1:0] scan_mask;
  logic [MASK_W-1:0] rem_mask;
  logic [IDX_W-1:0]  reg_idx;
  logic              mask_any;

  // In PASS the encoder looks at the incoming mask, in SEQ at what is left.
  assign scan_mask = (state_q == ST_SEQ) ? mask_q : ir_in[MASK_W-1:0];
  assign rem_mask  = scan_mask & ~(MASK_MSB >> reg_idx);

  lmsm_prio_enc u_prio_enc (
    .mask    (scan_mask),
    .idx     (reg_idx),
    .any_set (mask_any)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    mask_d  = mask_q;
    off_d   = off_q;

    if (flush) begin
      state_d = ST_PASS;
      ir_d    = '0;
      valid_d = 1'b0;
      mask_d  = '0;
      off_d   = '0;
    end else if (!stall) begin
      case (state_q)
        ST_PASS: begin
          if (!valid_in) begin
            valid_d = 1'b0;
          end else if (!is_lmsm(ir_in[OPC_LSB +: 4])) begin
            ir_d    = ir_in;
            pc_d    = pc_in;
            valid_d = 1'b1;
          end else if (!mask_any) begin
            valid_d = 1'b0;
          end else begin
            ir_d    = {micro_op(ir_in[OPC_LSB +: 4]), reg_idx,
                       ir_in[RA_LSB +: 3], {OFF_W{1'b0}}};
            pc_d    = pc_in;
            valid_d = 1'b1;
            if (rem_mask != '0) begin
              state_d = ST_SEQ;
              mask_d  = rem_mask;
              off_d   = OFF_W'(OFFSET_STEP);
            end else begin
              mask_d  = '0;
              off_d   = '0;
            end
          end
        end
        ST_SEQ: begin
          // Opcode and base were already placed in ir_q by the first micro-op.
          ir_d    = {ir_q[OPC_LSB +: 4], reg_idx, ir_q[RB_LSB +: 3], off_q};
          valid_d = 1'b1;
          mask_d  = rem_mask;
          off_d   = off_q + OFF_W'(OFFSET_STEP);
          if (rem_mask == '0) begin
            state_d = ST_PASS;
            off_d   = '0;
          end
        end
        default: begin
          state_d = ST_PASS;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PASS;
      ir_q    <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      mask_q  <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      mask_q  <= mask_d;
      off_q   <= off_d;
    end
  end

  // Handshake: upstream presents ir_in/valid_in and may advance IF/ID only on
  // an edge where hold_fetch was low; while high the same instruction is held.
  assign hold_fetch = stall | (state_q == ST_SEQ);
  assign lmsm_busy  = (state_q == ST_SEQ);

  assign ir_out     = ir_q;
  assign pc_out     = pc_q;
  assign valid_out  = valid_q;
  assign opcode_out = ir_q[OPC_LSB +: 4];
  assign ra_out     = ir_q[RA_LSB +: 3];
  assign rb_out     = ir_q[RB_LSB +: 3];
  assign rc_out     = ir_q[RC_LSB +: 3];
  assign imm6_out   = ir_q[5:0];
  assign imm9_out   = ir_q[8:0];

endmodule

// File: tb/tb_id_lmsm_expander.sv
// Bench for id_lmsm_expander: directed scenarios followed by randomized
// instruction streams checked against a list-based expansion model.
module tb_id_lmsm_expander;

  localparam int STEP = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir_in, pc_in;
  logic        valid_in, stall, flush;
  logic [15:0] ir_out, pc_out;
  logic        valid_out;
  logic [3:0]  opcode_out;
  logic [2:0]  ra_out, rb_out, rc_out;
  logic [5:0]  imm6_out;
  logic [8:0]  imm9_out;
  logic        hold_fetch, lmsm_busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  logic [15:0] last_ir, last_pc;
  logic        last_valid;

  always #5 clk = ~clk;

  id_lmsm_expander #(.OFFSET_STEP(STEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .ir_in      (ir_in),
    .pc_in      (pc_in),
    .valid_in   (valid_in),
    .stall      (stall),
    .flush      (flush),
    .ir_out     (ir_out),
    .pc_out     (pc_out),
    .valid_out  (valid_out),
    .opcode_out (opcode_out),
    .ra_out     (ra_out),
    .rb_out     (rb_out),
    .rc_out     (rc_out),
    .imm6_out   (imm6_out),
    .imm9_out   (imm9_out),
    .hold_fetch (hold_fetch),
    .lmsm_busy  (lmsm_busy)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] exp_ir, input logic exp_valid);
    chk({tag, "_valid"}, {15'b0, valid_out}, {15'b0, exp_valid});
    chk({tag, "_ir"}, ir_out, exp_ir);
    chk({tag, "_opc"}, {12'b0, opcode_out}, {12'b0, exp_ir[15:12]});
    chk({tag, "_ra"}, {13'b0, ra_out}, {13'b0, exp_ir[11:9]});
    chk({tag, "_rb"}, {13'b0, rb_out}, {13'b0, exp_ir[8:6]});
    chk({tag, "_rc"}, {13'b0, rc_out}, {13'b0, exp_ir[5:3]});
    chk({tag, "_imm6"}, {10'b0, imm6_out}, {10'b0, exp_ir[5:0]});
    chk({tag, "_imm9"}, {7'b0, imm9_out}, {7'b0, exp_ir[8:0]});
  endtask

  task automatic chk_ctl(input string tag, input logic exp_hold, input logic exp_busy);
    chk({tag, "_hold"}, {15'b0, hold_fetch}, {15'b0, exp_hold});
    chk({tag, "_busy"}, {15'b0, lmsm_busy}, {15'b0, exp_busy});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the list of instructions the RR stage should see for one
  // accepted fetch (empty list = dropped instruction).
  task automatic model_load(input logic [15:0] instr);
    logic [3:0] op;
    logic [2:0] r;
    int k;
    op = instr[15:12];
    if (op == 4'b0110 || op == 4'b0111) begin
      k = 0;
      for (int b = 7; b >= 0; b--) begin
        if (instr[b]) begin
          r = 3'(7 - b);
          exp_q.push_back({(op == 4'b0110) ? 4'b0100 : 4'b0101, r, instr[11:9], 6'(k * STEP)});
          k++;
        end
      end
    end else begin
      exp_q.push_back(instr);
    end
  endtask

  initial begin
    logic [15:0] instr, pc;
    logic [15:0] exp_ir;
    logic [3:0]  op;
    logic        accepted;
    int          cyc;

    // ---------------- reset ----------------
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    valid_in = 1'b0; ir_in = 16'h0; pc_in = 16'h0;
    tick(); tick();
    chk_out("reset", 16'h0000, 1'b0);
    chk_ctl("reset", 1'b0, 1'b0);
    chk("reset_pc", pc_out, 16'h0000);
    rst = 1'b0;

    // ---------------- pass-through ----------------
    ir_in = 16'h1298; pc_in = 16'h0010; valid_in = 1'b1;
    tick();
    chk_out("pass", 16'h1298, 1'b1);
    chk("pass_imm6", {10'b0, imm6_out}, 16'h0018);
    chk("pass_pc", pc_out, 16'h0010);

    // ---------------- LM expand, held follow-on instruction ----------------
    ir_in = 16'h62A1; pc_in = 16'h0020;
    tick();
    chk_out("lm0", 16'h4040, 1'b1);
    chk("lm0_pc", pc_out, 16'h0020);
    chk_ctl("lm0", 1'b1, 1'b1);
    ir_in = 16'h2ABC; pc_in = 16'h0021;
    tick();
    chk_out("lm1", 16'h4441, 1'b1);
    chk_ctl("lm1", 1'b1, 1'b1);
    tick();
    chk_out("lm2", 16'h4E42, 1'b1);
    chk("lm2_pc", pc_out, 16'h0020);
    chk_ctl("lm2", 1'b0, 1'b0);
    tick();
    chk_out("lm_next", 16'h2ABC, 1'b1);
    chk("lm_next_pc", pc_out, 16'h0021);

    // ---------------- stall during SEQ ----------------
    ir_in = 16'h62A1; pc_in = 16'h0030;
    tick();
    chk_out("st0", 16'h4040, 1'b1);
    ir_in = 16'h3000; pc_in = 16'h0031; stall = 1'b1;
    #1;
    chk_ctl("st_hold", 1'b1, 1'b1);
    tick();
    chk_out("st1", 16'h4040, 1'b1);
    tick();
    chk_out("st2", 16'h4040, 1'b1);
    stall = 1'b0;
    tick();
    chk_out("st3", 16'h4441, 1'b1);
    tick();
    chk_out("st4", 16'h4E42, 1'b1);
    tick();
    chk_out("st_next", 16'h3000, 1'b1);

    // ---------------- flush during SEQ ----------------
    ir_in = 16'h62A1; pc_in = 16'h0040;
    tick();
    chk_out("fl0", 16'h4040, 1'b1);
    flush = 1'b1; ir_in = 16'h1298; pc_in = 16'h0041;
    tick();
    chk_out("fl1", 16'h0000, 1'b0);
    chk_ctl("fl1", 1'b0, 1'b0);
    flush = 1'b0;
    tick();
    chk_out("fl_next", 16'h1298, 1'b1);
    chk("fl_next_pc", pc_out, 16'h0041);

    // ---------------- flush beats stall ----------------
    ir_in = 16'h62A1; pc_in = 16'h0050;
    tick();
    flush = 1'b1; stall = 1'b1;
    tick();
    chk_out("fs", 16'h0000, 1'b0);
    chk("fs_busy", {15'b0, lmsm_busy}, 16'h0000);
    flush = 1'b0; stall = 1'b0; ir_in = 16'h1298;
    tick();
    chk_out("fs_next", 16'h1298, 1'b1);

    // ---------------- empty mask ----------------
    ir_in = 16'h7200;
    #1;
    chk_ctl("empty_pre", 1'b0, 1'b0);
    tick();
    chk("empty_valid", {15'b0, valid_out}, 16'h0000);
    chk_ctl("empty", 1'b0, 1'b0);

    // ---------------- single-bit SM stays in PASS ----------------
    ir_in = 16'h7201; pc_in = 16'h0060;
    tick();
    chk_out("sm1", 16'h5E40, 1'b1);
    chk_ctl("sm1", 1'b0, 1'b0);

    // ---------------- full mask: offsets 0..7 ----------------
    ir_in = 16'h60FF; pc_in = 16'h0070;
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_ir = {4'b0100, 3'(k), 3'b000, 6'(k * STEP)};
      chk_out("full", exp_ir, 1'b1);
      chk_ctl("full", k < 7, k < 7);
      tick();
    end
    chk("full_after", {15'b0, valid_out}, 16'h0000);

    // ---------------- stall in PASS ----------------
    ir_in = 16'h1298; valid_in = 1'b1;
    tick();
    ir_in = 16'h5123; stall = 1'b1;
    tick();
    chk_out("pstall", 16'h1298, 1'b1);
    stall = 1'b0;
    tick();
    chk_out("pstall_next", 16'h5123, 1'b1);

    // ---------------- reset mid-sequence ----------------
    ir_in = 16'h62A1;
    tick();
    rst = 1'b1; valid_in = 1'b0;
    tick();
    chk_out("rst_mid", 16'h0000, 1'b0);
    chk_ctl("rst_mid", 1'b0, 1'b0);
    chk("rst_mid_pc", pc_out, 16'h0000);
    rst = 1'b0;

    // ---------------- randomized stream ----------------
    last_ir = 16'h0; last_pc = 16'h0; last_valid = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0: op = 4'b0110;
        1: op = 4'b0111;
        default: begin
          op = 4'($urandom_range(0, 15));
          if (op == 4'b0110 || op == 4'b0111) op = op - 4'd4;
        end
      endcase
      if (op == 4'b0110 || op == 4'b0111)
        instr = {op, 3'($urandom_range(0, 7)), 1'b0,
                 ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255))};
      else
        instr = {op, 12'($urandom)};
      pc = 16'($urandom);

      if ($urandom_range(0, 4) == 0) begin
        valid_in = 1'b0; stall = 1'b0;
        tick();
        chk("rnd_bubble", {15'b0, valid_out}, 16'h0000);
        last_valid = 1'b0;
      end

      ir_in = instr; pc_in = pc; valid_in = 1'b1;
      accepted = 1'b0;
      cyc = 0;
      while (!(accepted && exp_q.size() == 0)) begin
        if (cyc > 200) begin
          n_cmp++;
          n_err++;
          $error("FAIL rnd_timeout: observed no completion expected completion for %h", instr);
          break;
        end
        stall = ($urandom_range(0, 3) == 0);
        #1;
        chk_ctl("rnd", stall | (exp_q.size() > 0), exp_q.size() > 0);
        tick();
        if (stall) begin
          chk_out("rnd_stall", last_ir, last_valid);
          if (last_valid) chk("rnd_stall_pc", pc_out, last_pc);
        end else begin
          if (!accepted) begin
            model_load(instr);
            accepted = 1'b1;
          end
          if (exp_q.size() == 0) begin
            chk("rnd_drop", {15'b0, valid_out}, 16'h0000);
            last_valid = 1'b0;
          end else begin
            last_ir = exp_q.pop_front();
            last_pc = pc;
            last_valid = 1'b1;
            chk_out("rnd", last_ir, 1'b1);
            chk("rnd_pc", pc_out, pc);
          end
        end
        cyc++;
      end
      stall = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
